barrett_mulmod_ctrl: RTL and testbench



---
 rtl/ntt_pkg.sv | 38 +++
 rtl/barrett_mu_div.sv | 66 ++++++
 rtl/barrett_mulmod_ctrl.sv | 175 +++++++++++++++++
 tb/tb_barrett_mulmod_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT Barrett multiplier: controller states,
// default width, legal modulus bounds and the standard lattice moduli.
package ntt_pkg;

    localparam int W_DEF = 32;

    localparam logic [63:0] Q_MIN       = 64'd3;
    localparam logic [31:0] Q_KYBER     = 32'd3329;
    localparam logic [31:0] Q_DILITHIUM = 32'd8380417;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_READY = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Number of significant bits of x; applied to q-1 this is ceil(log2 q).
    function automatic int bit_len(input logic [63:0] x);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) begin
                n = i + 1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // A modulus is usable when it is odd and lies in [3, 2^(w-1)).
    function automatic logic q_is_legal(input logic [63:0] q, input int w);
        return (q >= Q_MIN) && (q < (64'd1 << (w - 1))) && q[0];
    endfunction

endpackage

// File: rtl/barrett_mu_div.sv
// Bit-serial restoring divider producing mu = floor(2^(2k) / q).
// The numerator is a single 1 followed by 2k zeros, so it is generated on
// the fly instead of being stored.
module barrett_mu_div #(
    parameter int W  = 32,
    parameter int KW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  mu
);

    logic [KW:0]  cnt_r;
    logic [W-1:0] rem_r;
    logic [W-1:0] quo_r;
    logic [W-1:0] mu_r;
    logic         first_r;
    logic [W:0]   rem_sh_s;
    logic [W:0]   rem_nx_s;
    logic         ge_s;

    assign busy = (cnt_r != {(KW+1){1'b0}});
    assign done = busy && (cnt_r == {{KW{1'b0}}, 1'b1});
    assign mu   = mu_r;

    // Shift in the next numerator bit and trial-subtract the modulus.
    always_comb begin
        rem_sh_s = {rem_r, first_r};
        ge_s     = (rem_sh_s >= {1'b0, q});
        if (ge_s) begin
            rem_nx_s = rem_sh_s - {1'b0, q};
        end else begin
            rem_nx_s = rem_sh_s;
        end
    end

    // Iteration counter, partial remainder/quotient and the published mu.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {(KW+1){1'b0}};
            rem_r   <= {W{1'b0}};
            quo_r   <= {W{1'b0}};
            mu_r    <= {W{1'b0}};
            first_r <= 1'b0;
        end else if (start) begin
            cnt_r   <= {k, 1'b1};
            rem_r   <= {W{1'b0}};
            quo_r   <= {W{1'b0}};
            first_r <= 1'b1;
        end else if (busy) begin
            cnt_r   <= cnt_r - {{KW{1'b0}}, 1'b1};
            rem_r   <= W'(rem_nx_s);
            quo_r   <= W'({quo_r, ge_s});
            first_r <= 1'b0;
            if (done) begin
                mu_r <= W'({quo_r, ge_s});
            end
        end
    end

endmodule

// File: rtl/barrett_mulmod_ctrl.sv
// Barrett modular multiplier: a configuration FSM derives k and mu for a
// new modulus, then operand pairs stream through an operand register and
// four arithmetic stages with a full-stall valid/ready handshake.
module barrett_mulmod_ctrl
    import ntt_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [W-1:0]  cfg_q,
    output logic          cfg_ready,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic [KW-1:0] cfg_k,
    output logic [W-1:0]  cfg_mu,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_r
);

    localparam int TW = W + 2;

    state_e        state_r;
    state_e        state_nx_s;
    logic [W-1:0]  q_r;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_s;
    logic          legal_s;
    logic          cfg_done_r;
    logic          cfg_err_r;
    logic          accept_s;
    logic          pipe_empty_s;
    logic          adv_s;
    logic          div_start_s;
    logic          div_busy_s;
    logic          div_done_s;
    logic [W-1:0]  mu_s;

    logic           v0_r, v1_r, v2_r, v3_r, v4_r;
    logic [W-1:0]   a0_r, b0_r;
    logic [2*W-1:0] z1_r, z2_r, m2_r;
    logic [TW-1:0]  t3_r;
    logic [W-1:0]   r4_r;
    logic [TW-1:0]  t_s;
    logic [TW-1:0]  r_s;

    assign k_s     = KW'(bit_len(64'(q_r) - 64'd1));
    assign legal_s = q_is_legal(64'(q_r), W);

    assign pipe_empty_s = !(v0_r || v1_r || v2_r || v3_r || v4_r);
    assign adv_s        = !(v4_r && !out_ready);
    assign cfg_ready    = ((state_r == ST_IDLE) || (state_r == ST_READY) ||
                           (state_r == ST_ERR)) && pipe_empty_s;
    assign accept_s     = cfg_start && cfg_ready;
    assign in_ready     = (state_r == ST_READY) && adv_s;

    assign cfg_done  = cfg_done_r;
    assign cfg_err   = cfg_err_r;
    assign cfg_k     = k_r;
    assign cfg_mu    = mu_s;
    assign out_valid = v4_r;
    assign out_r     = r4_r;

    barrett_mu_div #(.W(W), .KW(KW)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start_s),
        .k     (k_s),
        .q     (q_r),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .mu    (mu_s)
    );

    // Configuration FSM: next state and divider launch.
    always_comb begin
        state_nx_s  = state_r;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_READY, ST_ERR: begin
                if (accept_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_LOAD: begin
                if (legal_s) begin
                    state_nx_s  = ST_DIV;
                    div_start_s = 1'b1;
                end else begin
                    state_nx_s = ST_ERR;
                end
            end
            ST_DIV: begin
                if (div_done_s && div_busy_s) begin
                    state_nx_s = ST_READY;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered configuration status and parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            q_r        <= {W{1'b0}};
            k_r        <= {KW{1'b0}};
            cfg_done_r <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cfg_done_r <= (state_r == ST_DIV) && (state_nx_s == ST_READY);
            cfg_err_r  <= (state_nx_s == ST_ERR);
            if (accept_s) begin
                q_r <= cfg_q;
            end
            if (state_r == ST_LOAD) begin
                k_r <= k_s;
            end
        end
    end

    // Estimate-and-subtract step, then the final conditional corrections.
    always_comb begin
        t_s = TW'(z2_r - ((m2_r >> k_r) * {{W{1'b0}}, q_r}));
        if (t3_r >= {1'b0, q_r, 1'b0}) begin
            r_s = t3_r - {1'b0, q_r, 1'b0};
        end else if (t3_r >= {2'b00, q_r}) begin
            r_s = t3_r - {2'b00, q_r};
        end else begin
            r_s = t3_r;
        end
    end

    // Pipeline registers; every stage freezes together under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0; v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0; v4_r <= 1'b0;
            a0_r <= {W{1'b0}};
            b0_r <= {W{1'b0}};
            z1_r <= {(2*W){1'b0}};
            z2_r <= {(2*W){1'b0}};
            m2_r <= {(2*W){1'b0}};
            t3_r <= {TW{1'b0}};
            r4_r <= {W{1'b0}};
        end else if (adv_s) begin
            v0_r <= in_valid && in_ready;
            a0_r <= in_a;
            b0_r <= in_b;
            v1_r <= v0_r;
            z1_r <= {{W{1'b0}}, a0_r} * {{W{1'b0}}, b0_r};
            v2_r <= v1_r;
            z2_r <= z1_r;
            m2_r <= (z1_r >> k_r) * {{W{1'b0}}, mu_s};
            v3_r <= v2_r;
            t3_r <= t_s;
            v4_r <= v3_r;
            r4_r <= W'(r_s);
        end
    end

endmodule

// File: tb/tb_barrett_mulmod_ctrl.sv
// Directed bench for barrett_mulmod_ctrl: configuration latency and mu/k
// values, streaming results against a direct (a*b)%q model, backpressure,
// configuration errors and asynchronous reset mid-operation.
module tb_barrett_mulmod_ctrl;

    localparam int W  = 32;
    localparam int KW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [W-1:0]  cfg_q;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_err;
    logic [KW-1:0] cfg_k;
    logic [W-1:0]  cfg_mu;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_r;

    int total = 0;
    int bad   = 0;
    int pa[100];
    int pb[100];

    always #5 clk = ~clk;

    barrett_mulmod_ctrl #(.W(W), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_q     (cfg_q),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_k     (cfg_k),
        .cfg_mu    (cfg_mu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a configuration and measure edges from the accepting edge to cfg_done.
    task automatic cfg_wait_done(input logic [31:0] q, input int exp_edges, input string tag);
        int  edges;
        bit  seen;
        check({tag, " cfg_ready"}, cfg_ready, 1);
        @(negedge clk);
        cfg_q     = q;
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        edges = 0;
        seen  = 0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (cfg_done) seen = 1;
        end
        check({tag, " done latency"}, seen ? edges : -1, exp_edges);
        @(negedge clk);
        check({tag, " done pulse"}, cfg_done, 0);
    endtask

    // Issue a configuration expected to be rejected.
    task automatic cfg_bad(input logic [31:0] q, input string tag);
        @(negedge clk);
        cfg_q     = q;
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        check({tag, " err clear in load"}, cfg_err, 0);
        repeat (3) @(negedge clk);
        check({tag, " cfg_err"}, cfg_err, 1);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " cfg_ready"}, cfg_ready, 1);
        check({tag, " cfg_done"}, cfg_done, 0);
    endtask

    // Stream n pairs from pa/pb; optional 3-cycle out_ready stall at stall_at.
    task automatic run_stream(input int n, input longint unsigned q, input int stall_at,
                              output int cycles, output int first_v);
        logic [31:0] expq[$];
        int          sent, got, c, blocked;
        logic [31:0] held;
        sent = 0; got = 0; c = 0; blocked = 0; held = 32'd0;
        first_v = -1;
        while (got < n && c < 400) begin
            @(negedge clk);
            out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
            in_valid  = (sent < n);
            in_a      = (sent < n) ? pa[sent] : 32'd0;
            in_b      = (sent < n) ? pb[sent] : 32'd0;
            #1;
            if (out_valid && first_v < 0) first_v = c;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("extra result", 1, 0);
                end else begin
                    check("result", out_r, expq.pop_front());
                end
                got++;
            end
            if (!out_ready) begin
                if (c == stall_at) held = out_r;
                else check("stall hold out_r", out_r, held);
                check("stall out_valid", out_valid, 1);
                check("stall in_ready", in_ready, 0);
            end
            if (in_valid && in_ready) begin
                expq.push_back(32'((longint'(in_a) * longint'(in_b)) % q));
                sent++;
            end else if (in_valid && out_ready) begin
                blocked++;
            end
            c++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream count", got, n);
        check("stream no input stall", blocked, 0);
        check("stream drained", expq.size(), 0);
        cycles = c;
    endtask

    initial begin
        int cyc, fv, cnt;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_q = 32'd0;
        in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst cfg_done", cfg_done, 0);
        check("rst cfg_err", cfg_err, 0);
        check("rst cfg_k", cfg_k, 0);
        check("rst cfg_mu", cfg_mu, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_r", out_r, 0);
        check("rst cfg_ready", cfg_ready, 1);
        check("rst in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst cfg_ready", cfg_ready, 1);
        check("post-rst in_ready", in_ready, 0);

        // q = 17
        cfg_wait_done(32'd17, 12, "q17");
        check("q17 k", cfg_k, 5);
        check("q17 mu", cfg_mu, 60);
        check("q17 in_ready", in_ready, 1);
        pa[0] = 16; pb[0] = 16;
        run_stream(1, 17, -1, cyc, fv);
        check("q17 first result cycle", fv, 5);

        // q = 3329, 100 back-to-back pairs
        cfg_wait_done(32'd3329, 26, "q3329");
        check("q3329 k", cfg_k, 12);
        check("q3329 mu", cfg_mu, 5039);
        pa[0] = 3328; pb[0] = 3328;
        pa[1] = 0;    pb[1] = 1234;
        pa[2] = 2000; pb[2] = 0;
        for (int i = 3; i < 100; i++) begin
            pa[i] = $urandom_range(0, 3328);
            pb[i] = $urandom_range(0, 3328);
        end
        run_stream(100, 3329, -1, cyc, fv);
        check("q3329 throughput cycles", cyc, 105);
        check("q3329 first result cycle", fv, 5);

        // Backpressure mid-stream
        for (int i = 0; i < 40; i++) begin
            pa[i] = $urandom_range(0, 3328);
            pb[i] = $urandom_range(0, 3328);
        end
        run_stream(40, 3329, 20, cyc, fv);
        check("bp cycles", cyc, 48);

        // Configuration errors, then recovery with Dilithium
        cfg_bad(32'd16, "q16");
        cfg_bad(32'd1, "q1");
        cfg_wait_done(32'd8380417, 48, "qdil");
        check("qdil err", cfg_err, 0);
        check("qdil k", cfg_k, 23);
        check("qdil mu", cfg_mu, 8396807);
        pa[0] = 8380416; pb[0] = 8380416;
        pa[1] = 12345;   pb[1] = 67890;
        pa[2] = 8000000; pb[2] = 7999999;
        run_stream(3, 8380417, -1, cyc, fv);

        // Reset mid-divide
        @(negedge clk);
        cfg_q = 32'd3329; cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstdiv cfg_k", cfg_k, 0);
        check("rstdiv cfg_mu", cfg_mu, 0);
        check("rstdiv cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_done || in_ready) cnt++;
        end
        check("rstdiv no stale done", cnt, 0);

        // Reset with four pairs in flight
        cfg_wait_done(32'd3329, 26, "q3329b");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 32'(100 + i); in_b = 32'(7 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstpipe out_valid", out_valid, 0);
        check("rstpipe out_r", out_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rstpipe no stale out_valid", cnt, 0);
        check("rstpipe in_ready", in_ready, 0);
        check("rstpipe cfg_ready", cfg_ready, 1);
        check("rstpipe cfg_k", cfg_k, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
